// File: rtl/uart_tx_queue_if.sv
// rtl/uart_tx_queue_if.sv - push/status/serial bundle between debug controller and uart_tx_queue
interface uart_tx_queue_if;
  logic       tx_write;
  logic [7:0] tx_bus;
  logic       tx_full;
  logic       tx_done;
  logic       tx_idle;
  logic       tx_overflow;
  logic       tx;

  modport master (
    output tx_write, tx_bus,
    input  tx_full, tx_done, tx_idle, tx_overflow, tx
  );

  modport slave (
    input  tx_write, tx_bus,
    output tx_full, tx_done, tx_idle, tx_overflow, tx
  );
endinterface

// File: rtl/uart_tx_queue.sv
// rtl/uart_tx_queue.sv - byte FIFO feeding an 8N1 LSB-first UART transmitter
// Define UART_TX_PARITY_EN to insert an even-parity bit between DATA and STOP.
module uart_tx_queue #(
  parameter int BAUD_DIV = 5208,
  parameter int FIFO_AW  = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  uart_tx_queue_if.slave bus
);
  localparam int          DEPTH     = 1 << FIFO_AW;
  localparam int          CNT_W     = FIFO_AW + 1;
  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic [7:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               full, empty, push, pop;
  logic               overflow_q;

  state_t      state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        baud_last;
  logic        tx_q, tx_d, done_q, done_d, idle_q, idle_d;
  logic        par_bit;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  // A write while full is dropped even if a pop frees a slot in the same cycle.
  assign push      = bus.tx_write && !full;
  assign baud_last = (baud_q == BAUD_LAST);

  assign bus.tx_full     = full;
  assign bus.tx_done     = done_q;
  assign bus.tx_idle     = idle_q;
  assign bus.tx_overflow = overflow_q;
  assign bus.tx          = tx_q;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push && pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.tx_bus;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
      end
      count_q <= count_d;
      if (bus.tx_write && full) begin
        overflow_q <= 1'b1;
      end
    end
  end

`ifdef UART_TX_PARITY_EN
  logic par_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      par_q <= 1'b0;
    end else if (pop) begin
      par_q <= ^mem_q[rd_ptr_q];
    end
  end

  assign par_bit = par_q;
`else
  assign par_bit = 1'b1;
`endif

  // State register; line outputs are registered from the current state, so
  // tx/tx_done/tx_idle trail the state by one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
      idle_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
      idle_q  <= idle_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    shift_d = shift_q;
    bit_d   = bit_q;
    // Every state is left on its last baud cycle, so wrapping here also reloads on entry.
    baud_d  = (state_q == S_IDLE || baud_last) ? 16'd0 : baud_q + 16'd1;
    case (state_q)
      S_IDLE: begin
        bit_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_last) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (baud_last) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
      S_PARITY: begin
        if (baud_last) begin
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (baud_last) begin
          if (!empty) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tx_d   = 1'b1;
    done_d = 1'b0;
    idle_d = 1'b0;
    case (state_q)
      S_IDLE:   idle_d = empty;
      S_START:  tx_d   = 1'b0;
      S_DATA:   tx_d   = shift_q[0];
      S_PARITY: tx_d   = par_bit;
      S_STOP:   done_d = baud_last;
      default:  tx_d   = 1'b1;
    endcase
  end
endmodule

// File: tb/tb_uart_tx_queue.sv
// tb/tb_uart_tx_queue.sv - self-checking bench for uart_tx_queue at BAUD_DIV=4, FIFO_AW=4
module tb_uart_tx_queue;
  localparam int B     = 4;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FL    = NBITS * B;
  localparam int LIM   = 20000;

  typedef struct {
    logic [7:0] data;
    logic [7:0] line_seq;
    logic       par;
  } vec_t;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  uart_tx_queue_if bus ();

  uart_tx_queue #(.BAUD_DIV(B), .FIFO_AW(AW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial forever #5 clk = ~clk;

  int  n_chk      = 0;
  int  n_fail     = 0;
  int  done_cnt   = 0;
  int  frame_cnt  = 0;
  int  done_bad   = 0;
  int  gap_bad    = 0;
  int  unexp      = 0;
  bit  gap_chk_en = 1'b0;
  byte unsigned exp_q[$];
  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic frame_end(input logic [10:0] bits);
    logic [7:0] d;
    byte unsigned e;
    d = bits[8:1];
    if (exp_q.size() == 0) begin
      unexp++;
    end else begin
      e = exp_q.pop_front();
      check("frame_data", d, e);
`ifdef UART_TX_PARITY_EN
      check("parity_bit", bits[9], ^e);
`endif
    end
    check("stop_bit", bits[NBITS-1], 1);
  endtask

  // Serial decoder: samples mid-bit, checks tx_done lands on the final stop cycle.
  initial begin : monitor
    int          pos;
    bit          in_f;
    logic [10:0] bits;
    longint      ncyc, last_end;
    in_f = 0; pos = 0; bits = '0; ncyc = 0; last_end = -100;
    forever begin
      @(negedge clk);
      ncyc++;
      if (!reset_n) begin
        in_f = 0;
      end else begin
        if (bus.tx_done) done_cnt++;
        if (in_f) begin
          pos++;
        end else if (bus.tx === 1'b0) begin
          in_f = 1; pos = 0; bits = '0;
          if (gap_chk_en && (ncyc - last_end - 1) != 0) gap_bad++;
          frame_cnt++;
        end
        if (in_f) begin
          if (pos % B == B / 2) bits[pos / B] = bus.tx;
          if (pos == FL - 1) begin
            if (!bus.tx_done) done_bad++;
            frame_end(bits);
            in_f     = 0;
            last_end = ncyc;
          end else if (bus.tx_done) begin
            done_bad++;
          end
        end else if (bus.tx_done) begin
          done_bad++;
        end
      end
    end
  end

  task automatic push(input byte unsigned b, input bit model);
    bus.tx_bus   = b;
    bus.tx_write = 1'b1;
    @(posedge clk);
    #1;
    bus.tx_write = 1'b0;
    if (model) exp_q.push_back(b);
  endtask

  task automatic push_wait(input byte unsigned b);
    int t = 0;
    while (bus.tx_full && t < LIM) begin
      @(posedge clk); #1; t++;
    end
    if (bus.tx_full) check("full_holdoff_timeout", bus.tx_full, 0);
    push(b, 1'b1);
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((exp_q.size() != 0 || !bus.tx_idle) && t < LIM) begin
      @(posedge clk); #1; t++;
    end
    check("drain_queue_empty", exp_q.size(), 0);
    check("drain_idle", bus.tx_idle, 1);
  endtask

  task automatic check_reset_flags(input string tag);
    check({tag, "_tx"}, bus.tx, 1);
    check({tag, "_done"}, bus.tx_done, 0);
    check({tag, "_full"}, bus.tx_full, 0);
    check({tag, "_idle"}, bus.tx_idle, 1);
    check({tag, "_overflow"}, bus.tx_overflow, 0);
  endtask

  initial begin : main
    logic [63:0] got_tx, got_done, got_idle, et, ed, ei;
    int j, fc0, dc0, g;
    bus.tx_write = 1'b0;
    bus.tx_bus   = 8'h00;

    // line_seq holds the data bits in wire order, first-sent bit in [7]
    vecs[0] = '{8'hA5, 8'b10100101, 1'b0};
    vecs[1] = '{8'h07, 8'b11100000, 1'b1};
    vecs[2] = '{8'h3C, 8'b00111100, 1'b0};
    vecs[3] = '{8'h12, 8'b01001000, 1'b0};
    vecs[4] = '{8'h80, 8'b00000001, 1'b1};
    vecs[5] = '{8'h01, 8'b10000000, 1'b1};
    vecs[6] = '{8'hFF, 8'b11111111, 1'b0};
    vecs[7] = '{8'h6B, 8'b11010110, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    check_reset_flags("in_reset");
    reset_n = 1'b1;
    @(posedge clk); #1;
    check_reset_flags("after_reset");

    // Single-byte frames with full cycle-by-cycle trace comparison
    foreach (vecs[v]) begin
      wait_drain();
      push(vecs[v].data, 1'b1);
      got_tx = '1; got_done = '0; got_idle = '0;
      for (int k = 1; k < 64; k++) begin
        @(posedge clk); #1;
        got_tx[k]   = bus.tx;
        got_done[k] = bus.tx_done;
        got_idle[k] = bus.tx_idle;
      end
      for (int k = 0; k < 64; k++) begin
        if (k < 2 || k - 2 >= FL) begin
          et[k] = 1'b1;
        end else begin
          j = (k - 2) / B;
          if (j == 0)               et[k] = 1'b0;
          else if (j <= 8)          et[k] = vecs[v].line_seq[8-j];
          else if (j == NBITS - 1)  et[k] = 1'b1;
          else                      et[k] = vecs[v].par;
        end
        ed[k] = (k == FL + 1);
        ei[k] = (k >= FL + 2);
      end
      check($sformatf("vec%0d_tx_trace", v), got_tx, et);
      check($sformatf("vec%0d_done_trace", v), got_done, ed);
      check($sformatf("vec%0d_idle_trace", v), got_idle >> 2, ei >> 2);
    end

    // Burst of 176 bytes with writer hold-off: no gaps, one done per frame
    wait_drain();
    dc0 = done_cnt;
    fc0 = frame_cnt;
    gap_bad = 0;
    for (int i = 0; i < 176; i++) begin
      push_wait(8'(i));
      if (!gap_chk_en && frame_cnt > fc0) gap_chk_en = 1'b1;
    end
    wait_drain();
    gap_chk_en = 1'b0;
    check("burst_done_count", done_cnt - dc0, 176);
    check("burst_gaps", gap_bad, 0);
    check("burst_overflow", bus.tx_overflow, 0);

    // Random bytes and gaps against the scoreboard
    for (int i = 0; i < 40; i++) begin
      push_wait(8'($urandom));
      g = $urandom_range(0, 50);
      repeat (g) begin @(posedge clk); #1; end
    end
    wait_drain();
    check("random_overflow", bus.tx_overflow, 0);

    // Push on the same cycle STOP pops with three queued: occupancy must stay 3
    for (int i = 0; i < 4; i++) push(8'h40 + 8'(i), 1'b1);
    repeat (37) @(posedge clk);
    #1;
    push(8'h50, 1'b1);
    check("pp_done_aligned", bus.tx_done, 1);
    for (int i = 0; i < 12; i++) push(8'h60 + 8'(i), 1'b1);
    check("pp_not_full_at_15", bus.tx_full, 0);
    push(8'h6C, 1'b1);
    check("pp_full_at_16", bus.tx_full, 1);
    wait_drain();

    // Overflow: 18 back-to-back writes ignoring tx_full
    fc0 = frame_cnt;
    for (int i = 0; i < 16; i++) push(8'h80 + 8'(i), 1'b1);
    check("ovf_not_full_15", bus.tx_full, 0);
    push(8'h90, 1'b1);
    check("ovf_full_after_17", bus.tx_full, 1);
    check("ovf_clear_before_drop", bus.tx_overflow, 0);
    push(8'h91, 1'b0);
    check("ovf_sticky_set", bus.tx_overflow, 1);
    wait_drain();
    check("ovf_frames_sent", frame_cnt - fc0, 17);
    check("ovf_still_set", bus.tx_overflow, 1);

    // Reset during data bit 3 of 0x3C with four more bytes queued
    push(8'h3C, 1'b1);
    for (int i = 0; i < 4; i++) push(8'hC0 + 8'(i), 1'b1);
    repeat (15) @(posedge clk);
    #1;
    check("rst_pre_bit3", bus.tx, 1);
    check("rst_pre_busy", bus.tx_idle, 0);
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    check_reset_flags("mid_reset");
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    fc0 = frame_cnt;
    repeat (200) @(posedge clk);
    #1;
    check("rst_no_frames", frame_cnt - fc0, 0);
    check_reset_flags("post_release");
    push(8'h5A, 1'b1);
    wait_drain();
    check("rst_one_frame_after", frame_cnt - fc0, 1);

    check("spurious_or_missing_done", done_bad, 0);
    check("unexpected_frames", unexp, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
